// File: rtl/noc_pkg.sv
// Shared NoC types for the return-path merge tree.
// Packet layout: [8:5] address, [4:0] payload.
package noc_pkg;

  localparam int PKT_W   = 9;
  localparam int ADDR_HI = 8;
  localparam int ADDR_LO = 5;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    DATA = 2'd2
  } merge_state_t;

  // Address field of a packet; the merge node never inspects it.
  function automatic logic [ADDR_HI-ADDR_LO:0] addr_of(pkt_t p);
    return p[ADDR_HI:ADDR_LO];
  endfunction

endpackage

// File: rtl/merge13_node_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// On a tie the input that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Pick a winner from the request pair and the previous winner.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    unique case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/merge13_node.sv
// Two-to-one merge node: emits a source token on S, then the packet on Out.
// Per-input saturating counters track forwarded packets.
module merge13_node
  import noc_pkg::*;
#(
  parameter int W     = PKT_W,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [W-1:0]     In0_data,
  input  logic             In0_valid,
  output logic             In0_ready,
  input  logic [W-1:0]     In1_data,
  input  logic             In1_valid,
  output logic             In1_ready,
  output logic             S_data,
  output logic             S_valid,
  input  logic             S_ready,
  output logic [W-1:0]     Out_data,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  merge_state_t     r_state;
  logic             r_last_grant;
  logic             r_grant;
  logic             r_s_valid;
  logic             r_out_valid;
  logic [W-1:0]     r_pkt_buf;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_gnt_valid;
  logic             w_gnt_idx;
  logic             w_idle;
  logic             w_out_done;

  rr_arb2 u_arb (
    .req        ({In1_valid, In0_valid}),
    .last_grant (r_last_grant),
    .gnt_valid  (w_gnt_valid),
    .gnt_idx    (w_gnt_idx)
  );

  // Readies are gated by reset so nothing is accepted while held in reset.
  assign w_idle     = !RESET && (r_state == IDLE);
  assign In0_ready  = w_idle && w_gnt_valid && !w_gnt_idx;
  assign In1_ready  = w_idle && w_gnt_valid &&  w_gnt_idx;
  assign w_out_done = (r_state == DATA) && Out_ready;

  assign S_data    = r_grant;
  assign S_valid   = r_s_valid;
  assign Out_data  = r_pkt_buf;
  assign Out_valid = r_out_valid;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;
  assign busy      = (r_state != IDLE);

  // Accept -> S token -> packet sequencer with registered valids.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_pkt_buf    <= '0;
      r_s_valid    <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_pkt_buf <= w_gnt_idx ? In1_data : In0_data;
            r_grant   <= w_gnt_idx;
            r_s_valid <= 1'b1;
            r_state   <= SEL;
          end
        end
        SEL: begin
          if (S_ready) begin
            r_s_valid   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DATA;
          end
        end
        DATA: begin
          if (Out_ready) begin
            r_out_valid  <= 1'b0;
            r_last_grant <= r_grant;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_s_valid   <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Count each forwarded packet against its source, holding at full scale.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_out_done) begin
      if (!r_grant) begin
        if (r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + 1'b1;
      end else begin
        if (r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_merge13_node.sv
// Bench for merge13_node: cycle model plus S/Out scoreboard.
// Counters run at CNT_W = 2 so saturation is reachable.
module tb_merge13_node;

  localparam int W    = 9;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in0_data, in1_data;
  logic          in0_valid, in1_valid;
  logic          in0_ready, in1_ready;
  logic          s_data, s_valid, s_ready;
  logic [W-1:0]  out_data;
  logic          out_valid, out_ready;
  logic [CW-1:0] cnt0, cnt1;
  logic          busy;

  merge13_node #(.W(W), .CNT_W(CW)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .In0_data  (in0_data),
    .In0_valid (in0_valid),
    .In0_ready (in0_ready),
    .In1_data  (in1_data),
    .In1_valid (in1_valid),
    .In1_ready (in1_ready),
    .S_data    (s_data),
    .S_valid   (s_valid),
    .S_ready   (s_ready),
    .Out_data  (out_data),
    .Out_valid (out_valid),
    .Out_ready (out_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and reference model state.
  logic         q_s[$];
  logic [W-1:0] q_o[$];
  logic         s_log[$];
  logic [W-1:0] o_log[$];

  bit           mon_en = 0;
  int           m_state;
  logic         m_last, m_grant, pv, pg;
  logic [W-1:0] m_buf;
  int           m_cnt0, m_cnt1;

  // Check outputs against the model, then advance it to the next edge.
  always @(negedge clk) begin
    if (rst) begin
      m_state = 0;
      m_last  = 1'b1;
      m_cnt0  = 0;
      m_cnt1  = 0;
      q_s.delete();
      q_o.delete();
    end else if (mon_en) begin
      pv = in0_valid | in1_valid;
      pg = (in0_valid && in1_valid) ? !m_last : in1_valid;
      chk("in0_rdy", 32'(in0_ready), 32'(m_state == 0 && pv && !pg));
      chk("in1_rdy", 32'(in1_ready), 32'(m_state == 0 && pv && pg));
      chk("s_vld", 32'(s_valid), 32'(m_state == 1));
      chk("out_vld", 32'(out_valid), 32'(m_state == 2));
      chk("busy", 32'(busy), 32'(m_state != 0));
      chk("cnt0", 32'(cnt0), 32'(m_cnt0));
      chk("cnt1", 32'(cnt1), 32'(m_cnt1));
      if (m_state == 1) chk("s_hold", 32'(s_data), 32'(m_grant));
      if (m_state == 2) chk("o_hold", 32'(out_data), 32'(m_buf));
      case (m_state)
        0: if (pv) begin
          m_grant = pg;
          m_buf   = pg ? in1_data : in0_data;
          q_s.push_back(pg);
          q_o.push_back(m_buf);
          m_state = 1;
        end
        1: if (s_ready) begin
          if (q_s.size() == 0) chk("sb_s_empty", 32'(1), 32'(0));
          else chk("sb_s", 32'(s_data), 32'(q_s.pop_front()));
          s_log.push_back(s_data);
          m_state = 2;
        end
        2: if (out_ready) begin
          if (q_o.size() == 0) chk("sb_o_empty", 32'(1), 32'(0));
          else chk("sb_o", 32'(out_data), 32'(q_o.pop_front()));
          o_log.push_back(out_data);
          if (!m_grant) begin
            if (m_cnt0 != CMAX) m_cnt0++;
          end else begin
            if (m_cnt1 != CMAX) m_cnt1++;
          end
          m_last  = m_grant;
          m_state = 0;
        end
        default: m_state = 0;
      endcase
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    s_log.delete();
    o_log.delete();
  endtask

  // Offer one packet on a channel and hold it until accepted.
  task automatic send(input bit ch, input logic [W-1:0] d);
    int t = 0;
    if (ch) begin in1_data = d; in1_valid = 1'b1; end
    else    begin in0_data = d; in0_valid = 1'b1; end
    forever begin
      @(negedge clk);
      if ((ch ? in1_ready : in0_ready) || t > 200) break;
      t++;
    end
    if (t > 200) chk("send_timeout", 32'(t), 32'(0));
    @(posedge clk);
    #1;
    if (ch) in1_valid = 1'b0;
    else    in0_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (o_log.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (o_log.size() < n) chk("out_timeout", 32'(o_log.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_oval();
    int t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk("oval_timeout", 32'(0), 32'(1));
  endtask

  logic [CW-1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst       = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b0;
    in0_data  = 9'h1FF;
    in1_data  = '0;
    s_ready   = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in0_rdy", 32'(in0_ready), 32'(0));
    chk("rst_s_vld", 32'(s_valid), 32'(0));
    chk("rst_o_vld", 32'(out_valid), 32'(0));
    chk("rst_s_data", 32'(s_data), 32'(0));
    chk("rst_o_data", 32'(out_data), 32'(0));
    chk("rst_cnt", 32'({cnt1, cnt0}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    mon_en = 1;

    // Single source from In0.
    do_reset();
    send(0, 9'h1A5);
    wait_out(1);
    chk("t1_s", 32'(s_log[0]), 32'(0));
    chk("t1_o", 32'(o_log[0]), 32'h1A5);
    chk("t1_cnt0", 32'(cnt0), 32'(1));

    // Contention: grants alternate starting with In0.
    do_reset();
    fork
      begin send(0, 9'h0F0); send(0, 9'h0F0); end
      begin send(1, 9'h10F); send(1, 9'h10F); end
    join
    wait_out(4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_s", 32'(s_log[i]), 32'(i % 2));
      chk("t2_o", 32'(o_log[i]), (i % 2) ? 32'h10F : 32'h0F0);
    end
    chk("t2_cnt", 32'({cnt1, cnt0}), 32'({2'd2, 2'd2}));

    // Out back-pressure while In1 waits.
    do_reset();
    out_ready = 1'b0;
    fork
      send(0, 9'h0AA);
      begin @(posedge clk); #1; send(1, 9'h133); end
      begin
        wait_oval();
        repeat (5) @(posedge clk);
        #1;
        chk("t3_held", 32'(o_log.size()), 32'(0));
        out_ready = 1'b1;
      end
    join
    wait_out(2);
    chk("t3_o0", 32'(o_log[0]), 32'h0AA);
    chk("t3_o1", 32'(o_log[1]), 32'h133);
    chk("t3_n", 32'(o_log.size()), 32'(2));

    // S stall: Out must wait for the token.
    do_reset();
    s_ready = 1'b0;
    send(1, 9'h0C3);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_stall", 32'(o_log.size()), 32'(0));
    s_ready = 1'b1;
    wait_out(1);
    chk("t4_s", 32'(s_log[0]), 32'(1));
    chk("t4_o", 32'(o_log[0]), 32'h0C3);

    // Counter saturation on In1.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(1, 9'(9'h040 + k));
      wait_out(k + 1);
      chk("t5_cnt1", 32'(cnt1), 32'(sat_exp[k]));
    end

    // Asynchronous reset while a packet sits in DATA.
    do_reset();
    out_ready = 1'b0;
    send(0, 9'h155);
    wait_oval();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_async_ov", 32'(out_valid), 32'(0));
    chk("t6_cnt", 32'({cnt1, cnt0}), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    fork
      send(0, 9'h011);
      send(1, 9'h122);
    join
    wait_out(2);
    chk("t6_s0", 32'(s_log[0]), 32'(0));
    chk("t6_o0", 32'(o_log[0]), 32'h011);
    chk("t6_o1", 32'(o_log[1]), 32'h122);
    foreach (o_log[i]) if (o_log[i] == 9'h155) chk("t6_ghost", 32'(o_log[i]), 32'(0));
    chk("t6_n", 32'(o_log.size()), 32'(2));

    chk("sb_drain", 32'(q_s.size() + q_o.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
